// File: rtl/sdram_tgen_pkg.sv
// Shared types and the data-pattern generator for sdram_traffic_gen.
// Patterns are built at 64 bits and truncated by the caller to its data width.
package sdram_tgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_INCR,
    MODE_WALK,
    MODE_ADDR,
    MODE_CHECK
  } mode_t;

  localparam logic [63:0] CHECK_EVEN = {32{2'b01}};
  localparam logic [63:0] CHECK_ODD  = {32{2'b10}};

  // width is the caller's data width; the walking bit wraps modulo that width.
  function automatic logic [63:0] pattern(
    input logic [31:0] n,
    input logic        p_odd,
    input logic [63:0] addr,
    input mode_t       mode,
    input logic [63:0] seed,
    input logic [6:0]  width
  );
    logic [63:0] d;
    case (mode)
      MODE_INCR: d = seed + {16'b0, n, 16'b0} + {32'b0, n};
      MODE_WALK: d = 64'd1 << (n % {25'b0, width});
      MODE_ADDR: d = addr;
      default:   d = (n[0] ? CHECK_ODD : CHECK_EVEN) ^ {64{p_odd}};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sdram_traffic_gen.sv
// Write-then-readback traffic generator for the SDRAM controller request port.
// Define SDRAM_TGEN_TIMEOUT_EN to add a per-state watchdog and the timeout output.
module sdram_traffic_gen
  import sdram_tgen_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_WORDS      = 16,
  parameter int          NUM_PASSES     = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] ADDR_STRIDE    = 32'd4,
  parameter logic [31:0] SEED           = 32'hAB00CD00,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic [DATA_WIDTH-1:0] ctrl_write_data,
  output logic                  ctrl_wr,
  output logic                  ctrl_rd,
  input  logic                  ctrl_rdy,
  input  logic                  ctrl_wvalid,
  input  logic                  ctrl_rvalid,
  input  logic [DATA_WIDTH-1:0] ctrl_read_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pass_count,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
`ifdef SDRAM_TGEN_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  state_t                  state_reg, state_next;
  mode_t                   mode_reg;
  logic [31:0]             n_reg, p_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    stop_reg;
  logic [15:0]             pass_reg, err_reg;
  logic [ADDR_WIDTH-1:0]   ferr_addr_reg;
  logic [DATA_WIDTH-1:0]   ferr_data_reg;
  logic [DATA_WIDTH-1:0]   pat;
  logic active, start_ok, req_acc, wr_cpl, rd_cpl, adv;
  logic last_word, last_pass, stop_any, mismatch, tmo_fire, err_inc;

  assign pat = DATA_WIDTH'(pattern(n_reg, p_reg[0], 64'(addr_reg), mode_reg,
                                   64'(SEED), 7'(DATA_WIDTH)));

  assign active    = (state_reg == ST_WR_REQ) || (state_reg == ST_WR_WAIT) ||
                     (state_reg == ST_RD_REQ) || (state_reg == ST_RD_WAIT);
  assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign req_acc   = ((state_reg == ST_WR_REQ) || (state_reg == ST_RD_REQ)) && ctrl_rdy;
  assign wr_cpl    = (state_reg == ST_WR_WAIT) && ctrl_wvalid;
  assign rd_cpl    = (state_reg == ST_RD_WAIT) && ctrl_rvalid;
  assign adv       = req_acc || wr_cpl || rd_cpl;
  assign last_word = (n_reg == 32'(NUM_WORDS - 1));
  assign last_pass = (NUM_PASSES != 0) && (p_reg == 32'(NUM_PASSES - 1));
  assign stop_any  = stop_reg || stop;
  assign mismatch  = (ctrl_read_data != pat);
  assign err_inc   = (rd_cpl && mismatch) || tmo_fire;

`ifdef SDRAM_TGEN_TIMEOUT_EN
  logic [31:0] tmo_cnt_reg;
  logic        timeout_reg;

  assign tmo_fire = active && !adv && (tmo_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign timeout  = timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_next != state_reg) tmo_cnt_reg <= '0;
      else if (active)             tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
      if (start_ok)      timeout_reg <= 1'b0;
      else if (tmo_fire) timeout_reg <= 1'b1;
    end
  end
`else
  // Watchdog absent: the FSM waits indefinitely; the term keeps the parameter referenced.
  assign tmo_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_WR_REQ;
      ST_WR_REQ:        if (ctrl_rdy) state_next = ST_WR_WAIT;
      ST_WR_WAIT:
        if (ctrl_wvalid)
          state_next = stop_any ? ST_DONE : (last_word ? ST_RD_REQ : ST_WR_REQ);
      ST_RD_REQ:        if (ctrl_rdy) state_next = ST_RD_WAIT;
      ST_RD_WAIT:
        if (ctrl_rvalid)
          state_next = (stop_any || (last_word && last_pass)) ? ST_DONE :
                       (last_word ? ST_WR_REQ : ST_RD_REQ);
      default:          state_next = ST_IDLE;
    endcase
    if (tmo_fire) state_next = ST_DONE;
  end

  // Requests are decoded from the registered state, so they drop on the accepting edge.
  always_comb begin
    ctrl_wr         = (state_reg == ST_WR_REQ);
    ctrl_rd         = (state_reg == ST_RD_REQ);
    ctrl_write_data = ctrl_wr ? pat : '0;
    ctrl_addr       = addr_reg;
    busy            = active;
    done            = (state_reg == ST_DONE);
    pass_count      = pass_reg;
    error_count     = err_reg;
    first_err_addr  = ferr_addr_reg;
    first_err_data  = ferr_data_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg      <= MODE_INCR;
      n_reg         <= '0;
      p_reg         <= '0;
      addr_reg      <= '0;
      stop_reg      <= 1'b0;
      pass_reg      <= '0;
      err_reg       <= '0;
      ferr_addr_reg <= '0;
      ferr_data_reg <= '0;
    end else if (start_ok) begin
      mode_reg      <= mode_t'(mode);
      n_reg         <= '0;
      p_reg         <= '0;
      addr_reg      <= ADDR_WIDTH'(BASE_ADDR);
      stop_reg      <= 1'b0;
      pass_reg      <= '0;
      err_reg       <= '0;
      ferr_addr_reg <= '0;
      ferr_data_reg <= '0;
    end else begin
      if (active && stop) stop_reg <= 1'b1;
      if (wr_cpl || rd_cpl) begin
        n_reg    <= last_word ? 32'd0 : n_reg + 32'd1;
        addr_reg <= last_word ? ADDR_WIDTH'(BASE_ADDR) : addr_reg + ADDR_WIDTH'(ADDR_STRIDE);
      end
      if (rd_cpl && last_word) begin
        p_reg    <= p_reg + 32'd1;
        pass_reg <= pass_reg + 16'd1;
      end
      if (rd_cpl && mismatch && (err_reg == 16'd0)) begin
        ferr_addr_reg <= addr_reg;
        ferr_data_reg <= ctrl_read_data;
      end
      if (err_inc && (err_reg != 16'hFFFF)) err_reg <= err_reg + 16'd1;
    end
  end

endmodule
